// File: rtl/lpif_ll_tx_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : lpif_ll_tx_credit_fifo
// Purpose  : LPIF logic-link TX buffer; releases packed words toward AIB only
//            while far-end credits remain. Optional stall counter under
//            LPIF_TX_CREDIT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lpif_ll_tx_credit_fifo #(
    parameter int WIDTH      = 141,
    parameter int DEPTH      = 8,
    parameter int CREDIT_MAX = 8
) (
    input  logic                     clk_wr,
    input  logic                     rst_wr,
    input  logic [WIDTH-1:0]         txfifo_downstream_data,
    input  logic                     txfifo_downstream_push,
    output logic                     txfifo_downstream_ready,
    input  logic                     tx_online,
    input  logic                     credit_return,
    output logic [WIDTH-1:0]         tx_data,
    output logic                     tx_vld,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               credit_count,
    output logic                     overflow_err,
    output logic                     credit_err
`ifdef LPIF_TX_CREDIT_STATS_EN
    ,
    output logic [15:0]              stall_count
`endif
);

    localparam int           AW           = $clog2(DEPTH);
    localparam logic [AW:0]  c_depth      = (AW+1)'(DEPTH);
    localparam logic [AW:0]  c_lvl_one    = (AW+1)'(1);
    localparam logic [7:0]   c_credit_max = 8'(CREDIT_MAX);

    typedef enum logic [1:0] {
        ST_OFFLINE = 2'd0,
        ST_LOAD    = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [AW:0]        r_level;
    logic [7:0]         r_credit;
    logic [WIDTH-1:0]   r_tx_data;
    logic               r_tx_vld;
    logic               r_overflow_err;
    logic               r_credit_err;
    logic [WIDTH-1:0]   r_mem [DEPTH];
`ifdef LPIF_TX_CREDIT_STATS_EN
    logic [15:0]        r_stall_count;
`endif

    logic w_active;
    logic w_empty;
    logic w_ready;
    logic w_push;
    logic w_drop;
    logic w_pop;

    assign w_active = (r_state == ST_ACTIVE);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_ready  = w_active && (r_level < c_depth);
    assign w_push   = txfifo_downstream_push && w_ready;
    assign w_drop   = txfifo_downstream_push && !w_ready;
    // A link drop seen this cycle already suppresses new pops.
    assign w_pop    = w_active && tx_online && !w_empty && (r_credit != 8'd0);

    assign txfifo_downstream_ready = w_ready;
    assign tx_data                 = r_tx_data;
    assign tx_vld                  = r_tx_vld;
    assign fifo_level              = r_level;
    assign credit_count            = r_credit;
    assign overflow_err            = r_overflow_err;
    assign credit_err              = r_credit_err;
`ifdef LPIF_TX_CREDIT_STATS_EN
    assign stall_count             = r_stall_count;
`endif

    always_ff @(posedge clk_wr) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= txfifo_downstream_data;
        end
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            r_state        <= ST_OFFLINE;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_credit       <= 8'd0;
            r_tx_data      <= '0;
            r_tx_vld       <= 1'b0;
            r_overflow_err <= 1'b0;
            r_credit_err   <= 1'b0;
`ifdef LPIF_TX_CREDIT_STATS_EN
            r_stall_count  <= 16'd0;
`endif
        end else begin
            r_tx_vld <= 1'b0;
            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
            case (r_state)
                ST_OFFLINE: begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_level  <= '0;
                    r_credit <= 8'd0;
`ifdef LPIF_TX_CREDIT_STATS_EN
                    r_stall_count <= 16'd0;
`endif
                    if (tx_online) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_credit <= c_credit_max;
                    r_state  <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!tx_online) begin
                        r_state  <= ST_OFFLINE;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_level  <= '0;
                        r_credit <= 8'd0;
`ifdef LPIF_TX_CREDIT_STATS_EN
                        r_stall_count <= 16'd0;
`endif
                    end else begin
                        if (w_push) begin
                            r_wr_ptr <= r_wr_ptr + c_lvl_one;
                        end
                        if (w_pop) begin
                            r_rd_ptr  <= r_rd_ptr + c_lvl_one;
                            r_tx_data <= r_mem[r_rd_ptr[AW-1:0]];
                            r_tx_vld  <= 1'b1;
                        end
                        if (w_push && !w_pop) begin
                            r_level <= r_level + c_lvl_one;
                        end else if (!w_push && w_pop) begin
                            r_level <= r_level - c_lvl_one;
                        end
                        // Returns at the ceiling saturate and flag the far end.
                        if (w_pop && !credit_return) begin
                            r_credit <= r_credit - 8'd1;
                        end else if (!w_pop && credit_return) begin
                            if (r_credit == c_credit_max) begin
                                r_credit_err <= 1'b1;
                            end else begin
                                r_credit <= r_credit + 8'd1;
                            end
                        end
`ifdef LPIF_TX_CREDIT_STATS_EN
                        if (!w_empty && (r_credit == 8'd0) && (r_stall_count != 16'hFFFF)) begin
                            r_stall_count <= r_stall_count + 16'd1;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= ST_OFFLINE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lpif_ll_tx_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpif_ll_tx_credit_fifo
// Purpose  : Scoreboard bench for lpif_ll_tx_credit_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpif_ll_tx_credit_fifo;

    localparam int WIDTH = 141;

    logic               clk_wr;
    logic               rst_wr;
    logic [WIDTH-1:0]   txfifo_downstream_data;
    logic               txfifo_downstream_push;
    logic               txfifo_downstream_ready;
    logic               tx_online;
    logic               credit_return;
    logic [WIDTH-1:0]   tx_data;
    logic               tx_vld;
    logic [3:0]         fifo_level;
    logic [7:0]         credit_count;
    logic               overflow_err;
    logic               credit_err;
`ifdef LPIF_TX_CREDIT_STATS_EN
    logic [15:0]        stall_count;
`endif

    int checks;
    int errors;
    logic [WIDTH-1:0] exp_q[$];

    lpif_ll_tx_credit_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH      (8),
        .CREDIT_MAX (8)
    ) dut (
        .clk_wr                  (clk_wr),
        .rst_wr                  (rst_wr),
        .txfifo_downstream_data  (txfifo_downstream_data),
        .txfifo_downstream_push  (txfifo_downstream_push),
        .txfifo_downstream_ready (txfifo_downstream_ready),
        .tx_online               (tx_online),
        .credit_return           (credit_return),
        .tx_data                 (tx_data),
        .tx_vld                  (tx_vld),
        .fifo_level              (fifo_level),
        .credit_count            (credit_count),
        .overflow_err            (overflow_err),
        .credit_err              (credit_err)
`ifdef LPIF_TX_CREDIT_STATS_EN
        ,
        .stall_count             (stall_count)
`endif
    );

    initial clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    // Every emitted word must be the oldest word the model still expects.
    always @(negedge clk_wr) begin
        if (!rst_wr && tx_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: tx_data=%h emitted, none expected", tx_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL word_order: got %h, expected %h", tx_data, e);
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] mk_word();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) begin
            txfifo_downstream_data = mk_word();
            txfifo_downstream_push = 1'b1;
            exp_q.push_back(txfifo_downstream_data);
            tick();
        end
        txfifo_downstream_push = 1'b0;
    endtask

    task automatic bring_up();
        tx_online = 1'b0;
        tick();
        tick();
        exp_q.delete();
        tx_online = 1'b1;
        tick();
        tick();
    endtask

    task automatic exhaust_credits();
        push_burst(8);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_wr = 1'b1;
        tx_online = 1'b0;
        credit_return = 1'b0;
        txfifo_downstream_push = 1'b0;
        txfifo_downstream_data = '0;
        repeat (3) tick();
        checks++;
        if ({tx_vld, fifo_level, credit_count, overflow_err, credit_err, txfifo_downstream_ready} !== 16'h0
            || tx_data !== '0) begin
            errors++;
            $display("FAIL reset_values: vld=%b lvl=%0d cred=%0d ovf=%b cerr=%b rdy=%b data=%h, all required 0",
                     tx_vld, fifo_level, credit_count, overflow_err, credit_err, txfifo_downstream_ready, tx_data);
        end
        rst_wr = 1'b0;
        tick();
        tx_online = 1'b1;
        tick();
        checks++;
        if (txfifo_downstream_ready !== 1'b0 || credit_count !== 8'd0) begin
            errors++;
            $display("FAIL load_cycle: rdy=%b cred=%0d, required rdy=0 cred=0", txfifo_downstream_ready, credit_count);
        end
        tick();
        checks++;
        if (txfifo_downstream_ready !== 1'b1 || credit_count !== 8'd8 || overflow_err !== 1'b0 || credit_err !== 1'b0) begin
            errors++;
            $display("FAIL active_entry: rdy=%b cred=%0d ovf=%b cerr=%b, required 1/8/0/0",
                     txfifo_downstream_ready, credit_count, overflow_err, credit_err);
        end
    endtask

    task automatic test_credit_stall();
        int vld_in_window;
        logic vld_after;
        vld_in_window = 0;
        vld_after = 1'b0;
        for (int k = 0; k < 10; k++) begin
            txfifo_downstream_data = mk_word();
            txfifo_downstream_push = 1'b1;
            exp_q.push_back(txfifo_downstream_data);
            tick();
            if (k >= 1 && k <= 8 && tx_vld === 1'b1) vld_in_window++;
            if (k == 9) vld_after = tx_vld;
        end
        txfifo_downstream_push = 1'b0;
        checks++;
        if (vld_in_window != 8 || vld_after !== 1'b0) begin
            errors++;
            $display("FAIL stall_stream: %0d consecutive vld, trailing vld=%b; required 8 and 0", vld_in_window, vld_after);
        end
        tick();
        checks++;
        if (fifo_level !== 4'd2 || credit_count !== 8'd0 || tx_vld !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: lvl=%0d cred=%0d vld=%b, required 2/0/0", fifo_level, credit_count, tx_vld);
        end
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        checks++;
        if (tx_vld !== 1'b0 || credit_count !== 8'd1) begin
            errors++;
            $display("FAIL credit_in: vld=%b cred=%0d, required 0/1", tx_vld, credit_count);
        end
        tick();
        checks++;
        if (tx_vld !== 1'b1 || credit_count !== 8'd0 || fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL credit_release: vld=%b cred=%0d lvl=%0d, required 1/0/1", tx_vld, credit_count, fifo_level);
        end
    endtask

    task automatic test_full_overflow();
        bring_up();
        exhaust_credits();
        push_burst(8);
        checks++;
        if (fifo_level !== 4'd8 || txfifo_downstream_ready !== 1'b0 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL full: lvl=%0d rdy=%b ovf=%b, required 8/0/0", fifo_level, txfifo_downstream_ready, overflow_err);
        end
        txfifo_downstream_data = mk_word();
        txfifo_downstream_push = 1'b1;
        tick();
        txfifo_downstream_push = 1'b0;
        checks++;
        if (overflow_err !== 1'b1 || fifo_level !== 4'd8) begin
            errors++;
            $display("FAIL overflow: ovf=%b lvl=%0d, required 1/8", overflow_err, fifo_level);
        end
    endtask

    task automatic test_simultaneous();
        bring_up();
        checks++;
        if (overflow_err !== 1'b1 || credit_count !== 8'd8 || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL sticky_after_flush: ovf=%b cred=%0d lvl=%0d, required 1/8/0", overflow_err, credit_count, fifo_level);
        end
        txfifo_downstream_data = mk_word();
        txfifo_downstream_push = 1'b1;
        exp_q.push_back(txfifo_downstream_data);
        tick();
        txfifo_downstream_push = 1'b0;
        credit_return = 1'b1;
        tick();
        checks++;
        if (credit_count !== 8'd8 || tx_vld !== 1'b1 || credit_err !== 1'b0) begin
            errors++;
            $display("FAIL pop_and_return: cred=%0d vld=%b cerr=%b, required 8/1/0", credit_count, tx_vld, credit_err);
        end
        tick();
        credit_return = 1'b0;
        checks++;
        if (credit_count !== 8'd8 || credit_err !== 1'b1) begin
            errors++;
            $display("FAIL credit_saturate: cred=%0d cerr=%b, required 8/1", credit_count, credit_err);
        end
    endtask

    task automatic test_link_drop();
        int stale;
        stale = 0;
        bring_up();
        exhaust_credits();
        push_burst(5);
        checks++;
        if (fifo_level !== 4'd5) begin
            errors++;
            $display("FAIL queued5: lvl=%0d, required 5", fifo_level);
        end
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        tick();
        checks++;
        if (tx_vld !== 1'b1) begin
            errors++;
            $display("FAIL in_flight: vld=%b, required 1", tx_vld);
        end
        tx_online = 1'b0;
        tick();
        checks++;
        if (tx_vld !== 1'b0 || fifo_level !== 4'd0 || credit_count !== 8'd0 || txfifo_downstream_ready !== 1'b0) begin
            errors++;
            $display("FAIL link_drop: vld=%b lvl=%0d cred=%0d rdy=%b, required 0/0/0/0",
                     tx_vld, fifo_level, credit_count, txfifo_downstream_ready);
        end
        exp_q.delete();
        tx_online = 1'b1;
        tick();
        tick();
        checks++;
        if (credit_count !== 8'd8 || fifo_level !== 4'd0 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL relink: cred=%0d lvl=%0d ovf=%b, required 8/0/1", credit_count, fifo_level, overflow_err);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tx_vld === 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL stale_words: %0d stale words emitted, required 0", stale);
        end
    endtask

`ifdef LPIF_TX_CREDIT_STATS_EN
    task automatic test_stats();
        bring_up();
        exhaust_credits();
        push_burst(3);
        repeat (18) tick();
        checks++;
        if (stall_count !== 16'd20) begin
            errors++;
            $display("FAIL stall_count: got %0d, required 20", stall_count);
        end
        tx_online = 1'b0;
        tick();
        exp_q.delete();
        checks++;
        if (stall_count !== 16'd0) begin
            errors++;
            $display("FAIL stall_clear: got %0d, required 0", stall_count);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_credit_stall();
        test_full_overflow();
        test_simultaneous();
        test_link_drop();
`ifdef LPIF_TX_CREDIT_STATS_EN
        test_stats();
`endif
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
